// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light front end and sequencer:
// debounce state encoding, default timing constants and a clog2 helper.
package tl_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        CHECK_HIGH  = 2'd1,
        STABLE_HIGH = 2'd2,
        CHECK_LOW   = 2'd3
    } db_state_e;

    localparam int CLK_HZ      = 100000000;
    localparam int DEBOUNCE_MS = 20;

    // Width needed to hold values 0..value-1; never less than one bit.
    function automatic int tl_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/tl_timebase_request_if.sv
// Signals between the timebase/request front end and the sequencer side.
interface tl_timebase_request_if;

    logic btn_raw;
    logic req_ack;
    logic tick;
    logic half_tick;
    logic flash_phase;
    logic btn_level;
    logic ped_req;

    // master: the timebase/request block itself.
    modport master (
        input  btn_raw, req_ack,
        output tick, half_tick, flash_phase, btn_level, ped_req
    );

    modport slave (
        output btn_raw, req_ack,
        input  tick, half_tick, flash_phase, btn_level, ped_req
    );

endinterface

// File: rtl/tl_debounce.sv
// Two-flop synchroniser plus four-state debounce FSM for the pedestrian button.
// rise_o flags the edge on which btn_level_o is about to go 0->1.
module tl_debounce
    import tl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic rise_o
);

    localparam int CW = tl_clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DMAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic          sync1_q;
    logic          sync2_q;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any sample disagreeing with the candidate level drops back and restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state_q)
                STABLE_LOW: begin
                    if (sync2_q) begin
                        state_q <= CHECK_HIGH;
                        cnt_q   <= ONE;
                    end
                end
                CHECK_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == DMAX) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= CHECK_LOW;
                        cnt_q   <= ONE;
                    end
                end
                CHECK_LOW: begin
                    if (sync2_q) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == DMAX) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level_o = level_q;
    assign rise_o      = (state_q == CHECK_HIGH) && sync2_q && (cnt_q == DMAX);

endmodule

// File: rtl/tl_timebase_request.sv
// Timing enables (tick, half_tick, flash_phase) and the latched pedestrian
// crossing request that feed the traffic-light sequencer.
module tl_timebase_request
    import tl_pkg::*;
#(
    parameter int CYCLES_PER_TICK = CLK_HZ,
    parameter int DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS
) (
    input  logic                  clk,
    input  logic                  rst,
    tl_timebase_request_if.master bus
);

    localparam int PW = tl_clog2(CYCLES_PER_TICK);
    localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_TICK - 1);
    localparam logic [PW-1:0] HALF = PW'(CYCLES_PER_TICK / 2 - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;
    logic          tick_q;
    logic          half_q;
    logic          flash_q;
    logic          ped_req_q;
    logic          ped_req_d;
    logic          btn_level;
    logic          press_evt;
    logic          at_last;
    logic          at_half;

    tl_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_raw_i  (bus.btn_raw),
        .btn_level_o(btn_level),
        .rise_o     (press_evt)
    );

    assign at_last = (count_q == LAST);
    assign at_half = (count_q == HALF);

    // A fresh press outranks a simultaneous acknowledge.
    always_comb begin
        count_d   = at_last ? '0 : count_q + PW'(1);
        ped_req_d = press_evt | (ped_req_q & ~bus.req_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            tick_q    <= 1'b0;
            half_q    <= 1'b0;
            flash_q   <= 1'b0;
            ped_req_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            tick_q    <= at_last;
            half_q    <= at_last | at_half;
            flash_q   <= flash_q ^ (at_last | at_half);
            ped_req_q <= ped_req_d;
        end
    end

    assign bus.tick        = tick_q;
    assign bus.half_tick   = half_q;
    assign bus.flash_phase = flash_q;
    assign bus.btn_level   = btn_level;
    assign bus.ped_req     = ped_req_q;

endmodule

// File: tb/tb_tl_timebase_request.sv
// Directed bench for tl_timebase_request with CYCLES_PER_TICK=10, DEBOUNCE_CYCLES=4.
module tb_tl_timebase_request;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passes = 0;
    int   checks = 0;
    int   fails  = 0;
    int   e      = 0;

    tl_timebase_request_if bus ();

    tl_timebase_request #(
        .CYCLES_PER_TICK(10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s at edge %0d: got %b expected %b", tag, e, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"}, bus.tick, 1'b0);
        chk({tag, "_half"}, bus.half_tick, 1'b0);
        chk({tag, "_flash"}, bus.flash_phase, 1'b0);
        chk({tag, "_level"}, bus.btn_level, 1'b0);
        chk({tag, "_ped"}, bus.ped_req, 1'b0);
    endtask

    initial begin
        bus.btn_raw = 1'b0;
        bus.req_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        e = 0;

        // Timebase: tick every 10 edges, half_tick every 5, flash toggles with half_tick.
        for (int k = 1; k <= 40; k++) begin
            adv(1);
            chk("tick", bus.tick, ((k % 10) == 0));
            chk("half_tick", bus.half_tick, ((k % 5) == 0));
            chk("flash", bus.flash_phase, (((k / 5) % 2) == 1));
        end
        $display("timebase sweep done at edge %0d", e);

        // Clean press sampled at edge 100.
        adv(99 - e);
        bus.btn_raw = 1'b1;
        adv(1);
        chk("tick_during_btn", bus.tick, 1'b1);
        adv(5);
        chk("level_e105", bus.btn_level, 1'b0);
        chk("ped_e105", bus.ped_req, 1'b0);
        adv(1);
        chk("level_e106", bus.btn_level, 1'b1);
        chk("ped_e106", bus.ped_req, 1'b1);
        $display("press at edge 100: ped_req=%b at edge %0d", bus.ped_req, e);

        // Acknowledge clears; held button does not re-request.
        bus.req_ack = 1'b1;
        adv(1);
        bus.req_ack = 1'b0;
        chk("ack_clear", bus.ped_req, 1'b0);
        adv(5);
        chk("held_no_rereq", bus.ped_req, 1'b0);
        chk("held_level", bus.btn_level, 1'b1);
        bus.req_ack = 1'b1;
        adv(1);
        bus.req_ack = 1'b0;
        chk("ack_idle_noeffect", bus.ped_req, 1'b0);
        bus.btn_raw = 1'b0;
        adv(8);
        chk("release_level", bus.btn_level, 1'b0);
        chk("release_ped", bus.ped_req, 1'b0);
        bus.btn_raw = 1'b1;
        adv(6);
        chk("repress_e5", bus.ped_req, 1'b0);
        adv(1);
        chk("repress_e6", bus.ped_req, 1'b1);
        $display("ack/re-press done at edge %0d", e);

        // Clear, release, then bounce 1,0,1,0 followed by a held 1.
        bus.req_ack = 1'b1;
        adv(1);
        bus.req_ack = 1'b0;
        bus.btn_raw = 1'b0;
        adv(8);
        chk("pre_bounce_ped", bus.ped_req, 1'b0);
        for (int b = 0; b < 4; b++) begin
            bus.btn_raw = ((b % 2) == 0);
            adv(1);
            chk("bounce_ped", bus.ped_req, 1'b0);
        end
        bus.btn_raw = 1'b1;
        adv(1);
        for (int b = 1; b <= 5; b++) begin
            adv(1);
            chk("bounce_settle", bus.ped_req, 1'b0);
        end
        adv(1);
        chk("bounce_final", bus.ped_req, 1'b1);
        $display("bounce done at edge %0d ped_req=%b", e, bus.ped_req);

        // Acknowledge in the same cycle as the press event: press wins.
        bus.req_ack = 1'b1;
        adv(1);
        bus.req_ack = 1'b0;
        bus.btn_raw = 1'b0;
        adv(8);
        chk("pre_coinc_ped", bus.ped_req, 1'b0);
        bus.btn_raw = 1'b1;
        adv(6);
        chk("coinc_before", bus.ped_req, 1'b0);
        bus.req_ack = 1'b1;
        adv(1);
        bus.req_ack = 1'b0;
        chk("coinc_press_wins", bus.ped_req, 1'b1);
        adv(1);
        chk("coinc_hold", bus.ped_req, 1'b1);
        $display("coincident ack/press done at edge %0d", e);

        // Reset in the middle of a falling debounce window with ped_req pending.
        bus.btn_raw = 1'b0;
        adv(5);
        chk("pre_rst_ped", bus.ped_req, 1'b1);
        chk("pre_rst_level", bus.btn_level, 1'b1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        bus.btn_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("held_rst");
        rst = 1'b0;
        e = 0;
        adv(6);
        chk("post_rst_e6_level", bus.btn_level, 1'b0);
        chk("post_rst_e6_ped", bus.ped_req, 1'b0);
        adv(1);
        chk("post_rst_e7_level", bus.btn_level, 1'b1);
        chk("post_rst_e7_ped", bus.ped_req, 1'b1);
        adv(2);
        chk("post_rst_e9_tick", bus.tick, 1'b0);
        adv(1);
        chk("post_rst_e10_tick", bus.tick, 1'b1);
        $display("mid-operation reset done, post-release edge %0d", e);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
